lifo_fifo_buf: RTL
==================

LIFO_FIFO_BUF -- requirements
Module: lifo_fifo_buf

Interface
REQ-001 Parameter DWIDTH, default 8: data word width in bits.
REQ-002 Parameter AWIDTH, default 4: address width; DEPTH = 2**AWIDTH words.
REQ-003 Parameter AF_LEVEL, default 2**AWIDTH-2: almost-full threshold; range 1..DEPTH.
REQ-004 Parameter AE_LEVEL, default 2: almost-empty threshold; range 0..DEPTH-1.
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 srst_i  in  1  synchronous, active-high reset.
REQ-007 mode_i  in  1  requested mode: 0 = LIFO (stack), 1 = FIFO (queue).
REQ-008 wrreq_i  in  1  write request.
REQ-009 data_i  in  DWIDTH  write data.
REQ-010 rdreq_i  in  1  read request.
REQ-011 clr_err_i  in  1  clears sticky error flags.
REQ-012 q_o  out  DWIDTH  read data, registered.
REQ-013 mode_o  out  1  active mode.
REQ-014 empty_o, full_o  out  1 each  occupancy == 0 / occupancy == DEPTH.
REQ-015 almost_empty_o, almost_full_o  out  1 each  occupancy <= AE_LEVEL / occupancy >= AF_LEVEL.
REQ-016 usedw_o  out  AWIDTH+1  occupancy, 0..DEPTH.
REQ-017 overflow_o, underflow_o  out  1 each  sticky error flags.

Function
REQ-018 Storage SHALL be a single DEPTH x DWIDTH synchronous RAM: one write port, one registered read port.
REQ-019 All flags SHALL be registered, reflect occupancy after the previous edge, and never disagree with usedw_o.
REQ-020 Read accepted = rdreq_i && !empty_o; write accepted = wrreq_i && (!full_o || read accepted).
REQ-021 q_o SHALL update on the edge after an accepted read (1-cycle latency) and hold until the next accepted read; unaccepted reads leave q_o unchanged.
REQ-022 LIFO mode, read only: q_o <= most recently written unread word; occupancy -1.
REQ-023 LIFO mode, write only: word pushed on top; occupancy +1.
REQ-024 LIFO mode, read+write both accepted: q_o <= previous top; data_i replaces top; occupancy unchanged.
REQ-025 FIFO mode, read only: q_o <= oldest word; occupancy -1; write only: word appended; occupancy +1.
REQ-026 FIFO mode, read+write both accepted: both occur; occupancy unchanged; when occupancy is 1, q_o gets the stored word, not data_i.
REQ-027 Read with write while empty_o=1: write accepted, read rejected, underflow_o set, q_o unchanged.
REQ-028 Write while full_o=1 without accepted read: write dropped, memory unchanged, overflow_o set.
REQ-029 Read while empty_o=1: rejected, underflow_o set.
REQ-030 Pointers SHALL wrap modulo DEPTH; FIFO wrap SHALL be seamless across any number of laps.
REQ-031 mode_o SHALL load from mode_i only on an edge where empty_o=1 and wrreq_i=0; otherwise held.
REQ-032 On a mode load, pointers SHALL reinitialise and no stored data is lost (buffer is empty).
REQ-033 overflow_o/underflow_o SHALL stay set until clr_err_i=1; if clr_err_i and a new error coincide, the flag ends set.
REQ-034 No storage corruption or pointer slip SHALL occur at any boundary, in either mode.

Reset
REQ-035 On srst_i=1 at an edge: usedw_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0 (AF_LEVEL>0), overflow_o=0, underflow_o=0, q_o=0, mode_o<=mode_i, pointers=0.
REQ-036 srst_i SHALL override simultaneous wrreq_i/rdreq_i/clr_err_i; memory contents need not be cleared.
REQ-037 Reset mid-operation SHALL discard all stored words; the first read after reset reports underflow.

Verification (DWIDTH=8, AWIDTH=2, AF_LEVEL=3, AE_LEVEL=1)
REQ-038 LIFO: write 0x11,0x22,0x33,0x44 -> full_o=1, almost_full_o=1; 4 reads -> q_o 0x44,0x33,0x22,0x11, each 1 cycle after rdreq; empty_o=1.
REQ-039 FIFO: write 0xA1..0xA4, read 2, write 0xB1,0xB2, read 4 -> q_o 0xA1,0xA2,0xA3,0xA4,0xB1,0xB2 (pointer wrap).
REQ-040 Full, 5th write 0x55 with no read -> overflow_o=1, usedw_o=4, data intact; clr_err_i pulse -> overflow_o=0.
REQ-041 LIFO holding 0x11,0x22, read+write 0x99 same cycle -> q_o=0x22, usedw_o=2; next read -> q_o=0x99.
REQ-042 Empty, read+write 0x77 -> underflow_o=1, usedw_o=1, q_o unchanged; mode_i toggled while non-empty -> mode_o unchanged until drained.
REQ-043 Three words stored, srst_i pulse -> all outputs at REQ-035 values; read -> underflow_o=1.

Source files
------------

// File: rtl/lifo_fifo_buf.sv
// lifo_fifo_buf
//   Single-clock buffer that behaves as a stack (LIFO) or a queue (FIFO),
//   backed by one DEPTH x DWIDTH RAM with one write port and a registered
//   read port. The mode can only change while the buffer is empty, so a
//   mode change never loses stored data.
//
// Ports
//   clk_i          rising-edge clock
//   srst_i         synchronous active-high reset
//   mode_i         requested mode (0 = LIFO, 1 = FIFO)
//   wrreq_i/data_i write request and write data
//   rdreq_i        read request; q_o updates on the edge that accepts it
//   clr_err_i      clears the sticky overflow/underflow flags
//   q_o            registered read data
//   mode_o         active mode
//   empty_o/full_o/almost_empty_o/almost_full_o  registered occupancy flags
//   usedw_o        occupancy, 0..DEPTH
//   overflow_o/underflow_o  sticky error flags
module lifo_fifo_buf #(
    parameter int DWIDTH   = 8,
    parameter int AWIDTH   = 4,
    parameter int AF_LEVEL = 2**AWIDTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              mode_i,
    input  logic              wrreq_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              rdreq_i,
    input  logic              clr_err_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              mode_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_empty_o,
    output logic              almost_full_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int DEPTH = 2**AWIDTH;
    localparam logic [AWIDTH:0]   DEPTH_C = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0]   AF_C    = (AWIDTH+1)'(AF_LEVEL);
    localparam logic [AWIDTH:0]   AE_C    = (AWIDTH+1)'(AE_LEVEL);
    localparam logic [AWIDTH:0]   CNT_ONE = (AWIDTH+1)'(1);
    localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1);
    localparam logic              MODE_FIFO = 1'b1;

    // Storage RAM (no reset: contents are meaningless while empty)
    logic [DWIDTH-1:0] mem [DEPTH];

    logic [DWIDTH-1:0] q_q, q_d;
    logic              mode_q, mode_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              aempty_q, aempty_d;
    logic              afull_q, afull_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              rd_acc, wr_acc, mode_load;
    logic [AWIDTH:0]   cnt_m1;
    logic [AWIDTH-1:0] top_addr, raddr, waddr;

    always_comb begin
        rd_acc    = rdreq_i && !empty_q;
        // A read in the same cycle frees a slot, so a full buffer still
        // accepts the write.
        wr_acc    = wrreq_i && (!full_q || rd_acc);
        mode_load = empty_q && !wrreq_i;

        cnt_m1   = count_q - CNT_ONE;
        top_addr = cnt_m1[AWIDTH-1:0];

        // LIFO: the stack pointer is the occupancy itself. On a combined
        // read+write the new word overwrites the top slot; the RAM read is
        // read-before-write so q gets the old top.
        if (mode_q == MODE_FIFO) begin
            raddr = rd_ptr_q;
            waddr = wr_ptr_q;
        end else begin
            raddr = top_addr;
            waddr = rd_acc ? top_addr : count_q[AWIDTH-1:0];
        end

        q_d = rd_acc ? mem[raddr] : q_q;

        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (mode_q == MODE_FIFO) begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        // Mode loads only when empty with no write, so no access is accepted
        // in that cycle and restarting the pointers is safe.
        mode_d = mode_q;
        if (mode_load) begin
            mode_d   = mode_i;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end

        empty_d  = (count_d == '0);
        full_d   = (count_d == DEPTH_C);
        aempty_d = (count_d <= AE_C);
        afull_d  = (count_d >= AF_C);

        // Clear first so a coinciding new error wins.
        ovf_d = clr_err_i ? 1'b0 : ovf_q;
        udf_d = clr_err_i ? 1'b0 : udf_q;
        if (wrreq_i && full_q && !rd_acc) ovf_d = 1'b1;
        if (rdreq_i && empty_q)           udf_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            q_q      <= '0;
            mode_q   <= mode_i;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            q_q      <= q_d;
            mode_q   <= mode_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            aempty_q <= aempty_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc && !srst_i) mem[waddr] <= data_i;
    end

    assign q_o            = q_q;
    assign mode_o         = mode_q;
    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign almost_empty_o = aempty_q;
    assign almost_full_o  = afull_q;
    assign usedw_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;

endmodule
